// File: rtl/soc_system_seven_segment_pkg.sv
// Shared constants for the multi-digit seven-segment slave: register map, CTRL bits, hex glyphs.
// Latency: n/a (constants only).
// Backpressure: n/a.
package soc_system_seven_segment_pkg;

  // Word addresses within the slave
  localparam logic [3:0] ADDR_DATA     = 4'd0;
  localparam logic [3:0] ADDR_BLANK    = 4'd1;
  localparam logic [3:0] ADDR_BLINK    = 4'd2;
  localparam logic [3:0] ADDR_CTRL     = 4'd3;
  localparam logic [3:0] ADDR_RAW_BASE = 4'd8;

  // CTRL register bit positions
  localparam int CTRL_RAW_EN    = 0;
  localparam int CTRL_BLINK_RST = 1;
  localparam int CTRL_LAMP_TEST = 2;

  // Active-high glyphs, bit 0 = segment a; element k is the glyph for nibble value k
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/soc_system_seven_segment_multi_if.sv
// Avalon-MM slave bus bundle for the seven-segment register file.
// Latency: readdata is combinational, zero wait states; writes land on the next clk edge.
// Backpressure: none (no waitrequest); every access completes in one cycle.
// Signals: address[3:0], chipselect, write_n, writedata[31:0] (master -> slave), readdata[31:0] (slave -> master).
interface soc_system_seven_segment_multi_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);
endinterface

// File: rtl/soc_system_seven_segment_multi_hex_decode.sv
// Hex nibble to active-high seven-segment glyph (0-9, A, b, C, d, E, F).
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: nib_i[3:0] nibble in; seg_o[6:0] lit pattern out, bit 0 = segment a.
module seven_segment_hex_decode
  import soc_system_seven_segment_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_GLYPHS[nib_i];

endmodule

// File: rtl/soc_system_seven_segment_multi.sv
// Avalon-MM register file driving NUM_DIGITS seven-segment digits with hex/raw modes, blank, blink, lamp test.
// Latency: register write to pin is 2 clk edges; readdata is combinational.
// Backpressure: none; the slave accepts every access in a single cycle.
// Ports: clk, reset_n (async active-low), avs (Avalon slave bus), out_port[7*NUM_DIGITS-1:0] (digit i at [7i+6:7i]).
module soc_system_seven_segment_multi
  import soc_system_seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  soc_system_seven_segment_multi_if.slave avs,
  output logic [7*NUM_DIGITS-1:0]   out_port
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [DW-1:0]         data_q;
  logic [NUM_DIGITS-1:0] blank_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic                  raw_en_q;
  logic                  lamp_q;
  logic [6:0]            raw_q [NUM_DIGITS];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] out_q, out_d;

  logic wr_en;
  logic blink_rst;

  assign wr_en     = avs.chipselect && !avs.write_n;
  assign blink_rst = wr_en && (avs.address == ADDR_CTRL) && avs.writedata[CTRL_BLINK_RST];

  // Register file; BLINK_RST is not stored, it only acts on the blink generator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      blank_q  <= '0;
      blink_q  <= '0;
      raw_en_q <= 1'b0;
      lamp_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) raw_q[i] <= '0;
    end else if (wr_en) begin
      case (avs.address)
        ADDR_DATA:  data_q  <= avs.writedata[DW-1:0];
        ADDR_BLANK: blank_q <= avs.writedata[NUM_DIGITS-1:0];
        ADDR_BLINK: blink_q <= avs.writedata[NUM_DIGITS-1:0];
        ADDR_CTRL: begin
          raw_en_q <= avs.writedata[CTRL_RAW_EN];
          lamp_q   <= avs.writedata[CTRL_LAMP_TEST];
        end
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (avs.address == ADDR_RAW_BASE + 4'(i)) raw_q[i] <= avs.writedata[6:0];
        end
      endcase
    end
  end

  // Blink generator: software restart beats the natural wrap
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (blink_rst) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  logic [6:0] glyph [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seven_segment_hex_decode u_dec (
      .nib_i (data_q[4*g +: 4]),
      .seg_o (glyph[g])
    );
  end

  // Per-digit lit pattern by priority, then polarity applied
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic [6:0] pat;
      pat = glyph[i];
      if (lamp_q)                     pat = 7'h7F;
      else if (blank_q[i])            pat = 7'h00;
      else if (blink_q[i] && phase_q) pat = 7'h00;
      else if (raw_en_q)              pat = raw_q[i];
      out_d[7*i +: 7] = pat ^ {7{ACTIVE_LOW}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= {(7*NUM_DIGITS){ACTIVE_LOW}};
    else          out_q <= out_d;
  end

  assign out_port = out_q;

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_DATA:  avs.readdata[DW-1:0]         = data_q;
      ADDR_BLANK: avs.readdata[NUM_DIGITS-1:0] = blank_q;
      ADDR_BLINK: avs.readdata[NUM_DIGITS-1:0] = blink_q;
      ADDR_CTRL: begin
        avs.readdata[CTRL_RAW_EN]    = raw_en_q;
        avs.readdata[CTRL_LAMP_TEST] = lamp_q;
      end
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (avs.address == ADDR_RAW_BASE + 4'(i)) avs.readdata[6:0] = raw_q[i];
      end
    endcase
  end

endmodule

// File: tb/tb_soc_system_seven_segment_multi.sv
// Bench for soc_system_seven_segment_multi with NUM_DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1.
// Behavioural model tracks registers and elapsed cycles since the last blink restart.
module tb_soc_system_seven_segment_multi;

  localparam int ND  = 6;
  localparam int DIV = 4;
  localparam logic [41:0] DARK = {42{1'b1}};

  logic        clk;
  logic        reset_n;
  logic [41:0] out_port;

  soc_system_seven_segment_multi_if bus ();

  soc_system_seven_segment_multi #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (DIV),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus.slave),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [23:0] m_data;
  logic [5:0]  m_blank, m_blink;
  logic        m_raw_en, m_lamp;
  logic [6:0]  m_raw [ND];
  int          m_ticks;   // clk edges since reset release or last blink restart
  logic [41:0] m_out;

  function automatic logic [41:0] model_out();
    logic [41:0] o;
    logic [6:0]  p;
    bit          ph;
    ph = ((m_ticks / DIV) % 2) == 1;
    o  = '0;
    for (int i = 0; i < ND; i++) begin
      if (m_lamp)                  p = 7'h7F;
      else if (m_blank[i])         p = 7'h00;
      else if (m_blink[i] && ph)   p = 7'h00;
      else if (m_raw_en)           p = m_raw[i];
      else                         p = glyph_tab[m_data[4*i +: 4]];
      o[7*i +: 7] = ~p;
    end
    return o;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = '0; m_blank = '0; m_blink = '0; m_raw_en = 0; m_lamp = 0;
      for (int i = 0; i < ND; i++) m_raw[i] = '0;
      m_ticks = 0;
      m_out   = DARK;
    end else begin
      m_out = model_out();
      m_ticks++;
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          4'd0: m_data  = bus.writedata[23:0];
          4'd1: m_blank = bus.writedata[5:0];
          4'd2: m_blink = bus.writedata[5:0];
          4'd3: begin
            m_raw_en = bus.writedata[0];
            m_lamp   = bus.writedata[2];
            if (bus.writedata[1]) m_ticks = 0;
          end
          default: if (bus.address >= 4'd8 && bus.address < 4'd14)
                     m_raw[bus.address - 4'd8] = bus.writedata[6:0];
        endcase
      end
    end
  end

  // Every-cycle output comparison against the model
  always @(negedge clk) chk("out_port_model", {22'd0, out_port}, {22'd0, m_out});

  // ---------------- stimulus helpers ----------------
  task automatic wr_now(input logic [3:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.address = a;
    #1;
    chk(name, {32'd0, bus.readdata}, {32'd0, exp});
  endtask

  function automatic logic [6:0] dig(input int i);
    return out_port[7*i +: 7];
  endfunction

  initial begin
    reset_n = 1'b0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", {22'd0, out_port}, {22'd0, DARK});
    reset_n = 1'b1;

    // 1: hex data
    wr(4'd0, 32'h0001_2345);
    @(negedge clk);
    chk("t1_dig0", {57'd0, dig(0)}, {57'd0, 7'h12});
    chk("t1_dig1", {57'd0, dig(1)}, {57'd0, 7'h19});
    chk("t1_dig2", {57'd0, dig(2)}, {57'd0, 7'h30});
    chk("t1_dig5", {57'd0, dig(5)}, {57'd0, 7'h40});
    rd_chk("t1_rd_data", 4'd0, 32'h0001_2345);

    // 2: raw mode
    wr(4'd10, 32'hFFFF_FF49);
    wr(4'd3, 32'h1);
    @(negedge clk);
    for (int i = 0; i < ND; i++)
      chk($sformatf("t2_raw_dig%0d", i), {57'd0, dig(i)}, {57'd0, (i == 2) ? 7'h36 : 7'h7F});
    rd_chk("t2_rd_raw2", 4'd10, 32'h49);
    rd_chk("t2_rd_ctrl", 4'd3, 32'h1);
    wr(4'd3, 32'h0);
    @(negedge clk);
    chk("t2_hex_back", {57'd0, dig(0)}, {57'd0, 7'h12});

    // 3: blink, with a restart landing on a wrap cycle while phase is 0
    wr(4'd0, 32'h8);
    wr(4'd2, 32'h1);
    begin
      int n = 0;
      while ((m_ticks % (2*DIV)) != DIV - 1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t3_wait_wrap", 64'(n < 50), 64'd1);
    end
    wr_now(4'd3, 32'h2);
    for (int k = 1; k <= 2*DIV; k++) begin
      @(negedge clk);
      chk($sformatf("t3_blink_k%0d", k), {57'd0, dig(0)}, {57'd0, (k <= DIV) ? 7'h00 : 7'h7F});
    end
    repeat (12) @(negedge clk);

    // 4: lamp test overrides blank
    wr(4'd1, 32'h3F);
    wr(4'd3, 32'h4);
    @(negedge clk);
    chk("t4_lamp", {22'd0, out_port}, 64'd0);
    wr(4'd3, 32'h0);
    @(negedge clk);
    chk("t4_blanked", {22'd0, out_port}, {22'd0, DARK});

    // 5: unmapped addresses and write-1 pulse readback
    rd_chk("t5_rd4", 4'd4, 32'h0);
    rd_chk("t5_rd7", 4'd7, 32'h0);
    rd_chk("t5_rd14", 4'd14, 32'h0);
    rd_chk("t5_rd15", 4'd15, 32'h0);
    wr(4'd3, 32'h2);
    rd_chk("t5_ctrl_pulse", 4'd3, 32'h0);
    wr(4'd5, 32'hFFFF_FFFF);
    rd_chk("t5_data", 4'd0, 32'h8);
    rd_chk("t5_blank", 4'd1, 32'h3F);
    rd_chk("t5_blink", 4'd2, 32'h1);
    rd_chk("t5_ctrl", 4'd3, {29'd0, m_lamp, 1'b0, m_raw_en});
    rd_chk("t5_raw2", 4'd10, {25'd0, m_raw[2]});

    // 6: async reset mid-blink
    wr(4'd1, 32'h0);
    wr(4'd0, 32'h0012_3456);
    wr(4'd3, 32'h1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_out", {22'd0, out_port}, {22'd0, DARK});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_chk("t6_data", 4'd0, 32'h0);
    rd_chk("t6_blank", 4'd1, 32'h0);
    rd_chk("t6_blink", 4'd2, 32'h0);
    rd_chk("t6_ctrl", 4'd3, 32'h0);
    rd_chk("t6_raw2", 4'd10, 32'h0);
    @(negedge clk);
    chk("t6_out_after", {57'd0, dig(0)}, {57'd0, 7'h40});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
